// File: rtl/riscv_register_file_if.sv
// Register-file access bundle: two read ports and one write port, as seen from decode/writeback.
interface riscv_register_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              WriteEnable;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;

    modport master (
        output rs1, rs2, rd, WriteEnable, data,
        input  data1, data2
    );

    modport slave (
        input  rs1, rs2, rd, WriteEnable, data,
        output data1, data2
    );
endinterface

// File: rtl/riscv_register_file.sv
// RV32I integer register file: 2 combinational read ports, 1 synchronous write port, x0 = 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module riscv_register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic                 clk,
    input logic                 rst,
    riscv_register_file_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic              wr_en;

    assign wr_en = bus.WriteEnable && (bus.rd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.rd] <= bus.data;
        end
    end

    // Address 0 and reset are gated on the read path so x0 stays zero regardless of storage.
    always_comb begin
        bus.data1 = '0;
        bus.data2 = '0;
        if (rst) begin
            if (bus.rs1 != '0) begin
                bus.data1 = regs_q[bus.rs1];
            end
            if (bus.rs2 != '0) begin
                bus.data2 = regs_q[bus.rs2];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (bus.rs1 == bus.rd)) begin
                bus.data1 = bus.data;
            end
            if (wr_en && (bus.rs2 == bus.rd)) begin
                bus.data2 = bus.data;
            end
`endif
        end
    end
endmodule

// File: tb/tb_riscv_register_file.sv
// Directed self-checking bench for riscv_register_file; expectations adapt to REGFILE_BYPASS_EN.
module tb_riscv_register_file;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    riscv_register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    riscv_register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.rs1 = 5'(($urandom % 31) + 1);
        bus.rs2 = 5'(($urandom % 31) + 1);
        bus.rd = 5'd3;
        bus.WriteEnable = 1'b1;
        bus.data = 32'hDEAD_BEEF;
        tick();
        check("rst_data1", bus.data1, 32'h0);
        check("rst_data2", bus.data2, 32'h0);

        rst = 1'b1;
        bus.WriteEnable = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.rs1 = 5'(i);
            bus.rs2 = 5'(31 - i);
            #1;
            check("clear_data1", bus.data1, 32'h0);
            check("clear_data2", bus.data2, 32'h0);
        end

        // First write, x2 = 1
        bus.WriteEnable = 1'b1;
        bus.rd = 5'd2;
        bus.data = 32'h0000_0001;
        bus.rs1 = 5'd3;
        bus.rs2 = 5'd2;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x2_pre_edge", bus.data2, 32'h0000_0001);
`else
        check("x2_pre_edge", bus.data2, 32'h0);
`endif
        tick();
        check("x2_data2", bus.data2, 32'h0000_0001);
        check("x3_data1", bus.data1, 32'h0);

        // Write to x0 discarded
        bus.rd = 5'd0;
        bus.data = 32'hFFFF_FFFF;
        bus.rs1 = 5'd0;
        #1;
        check("x0_pre_edge", bus.data1, 32'h0);
        tick();
        check("x0_data1", bus.data1, 32'h0);
        check("x2_kept", bus.data2, 32'h0000_0001);

        // WriteEnable gating
        bus.WriteEnable = 1'b0;
        bus.rd = 5'd1;
        bus.rs1 = 5'd1;
        tick();
        check("we0_x1", bus.data1, 32'h0);
        bus.WriteEnable = 1'b1;
        tick();
        check("we1_x1", bus.data1, 32'hFFFF_FFFF);

        // x5 and x31, dual read of same register
        bus.rd = 5'd5;
        bus.data = 32'hA5A5_A5A5;
        tick();
        bus.rd = 5'd31;
        bus.data = 32'h5A5A_5A5A;
        tick();
        bus.WriteEnable = 1'b0;
        bus.rs1 = 5'd5;
        bus.rs2 = 5'd5;
        #1;
        check("x5_data1", bus.data1, 32'hA5A5_A5A5);
        check("x5_data2", bus.data2, 32'hA5A5_A5A5);
        bus.rs2 = 5'd31;
        #1;
        check("x31_data2", bus.data2, 32'h5A5A_5A5A);

        // Mid-cycle reset with a pending write
        bus.WriteEnable = 1'b1;
        bus.rd = 5'd5;
        bus.data = 32'h1357_9BDF;
        #1;
        rst = 1'b0;
        #1;
        check("midrst_data1", bus.data1, 32'h0);
        check("midrst_data2", bus.data2, 32'h0);
        tick();
        check("rst_blocks_wr", bus.data1, 32'h0);
        #2;
        bus.WriteEnable = 1'b0;
        rst = 1'b1;
        #1;
        check("post_rst_x5", bus.data1, 32'h0);
        check("post_rst_x31", bus.data2, 32'h0);

        // Same-cycle read of a register being written
        bus.WriteEnable = 1'b1;
        bus.rd = 5'd7;
        bus.data = 32'h1111_1111;
        tick();
        bus.data = 32'h1234_5678;
        bus.rs1 = 5'd7;
        bus.rs2 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x7_same_cycle1", bus.data1, 32'h1234_5678);
        check("x7_same_cycle2", bus.data2, 32'h1234_5678);
`else
        check("x7_same_cycle1", bus.data1, 32'h1111_1111);
        check("x7_same_cycle2", bus.data2, 32'h1111_1111);
`endif
        tick();
        check("x7_after_edge", bus.data1, 32'h1234_5678);

        bus.rd = 5'd0;
        bus.data = 32'hFFFF_FFFF;
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;
        #1;
        check("x0_fwd_data1", bus.data1, 32'h0);
        check("x0_fwd_data2", bus.data2, 32'h0);
        tick();
        check("x0_after_edge", bus.data1, 32'h0);
        bus.WriteEnable = 1'b0;
        bus.rs1 = 5'd7;
        #1;
        check("x7_retained", bus.data1, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_register_file.md
Name: riscv_register_file

Overview:
- Integer register file for the RV32I pipeline: 2**ADDR_W registers of DATA_W bits, two combinational read ports and one synchronous write port.
- Sits in the decode stage. Read ports feed the operand latches; the write port is driven by writeback.
- Register x0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register address width; register count = 2**ADDR_W (32).

Ports:
- clk  input  1  system clock; writes on rising edge.
- rst  input  1  asynchronous reset, active-low; clears all registers.
- rs1  input  ADDR_W  read port 1 address.
- rs2  input  ADDR_W  read port 2 address.
- rd  input  ADDR_W  write address.
- WriteEnable  input  1  write strobe; active-high.
- data  input  DATA_W  write data.
- data1  output  DATA_W  contents of register rs1.
- data2  output  DATA_W  contents of register rs2.

Behaviour:
- Storage: array reg[0..2**ADDR_W-1], each DATA_W bits.
- Reset:
  - rst=0 immediately clears every register to 0, independent of clk.
  - While rst=0, writes are ignored and data1/data2 read 0.
  - Release is synchronous-safe: the first write can occur on the first rising edge with rst=1.
- Write:
  - On a rising clk edge with rst=1, WriteEnable=1 and rd!=0: reg[rd] <= data.
  - WriteEnable=0: no register changes.
  - Write latency is 1 edge; the new value is visible on the read ports immediately after that edge.
- x0:
  - A write with rd=0 is discarded, whatever the value of WriteEnable or data.
  - reg[0] always reads 0. The read path also forces data=0 when the address is 0, so x0 is zero even if storage were corrupted.
- Read:
  - Purely combinational: data1 = (rs1==0) ? 0 : reg[rs1]; data2 likewise for rs2.
  - No clock latency; outputs follow address changes within the same cycle.
- Simultaneous events:
  - Both read ports may address the same register; both return the same value.
  - Reading rd during the cycle it is being written returns the old value until the edge (default build, no bypass).
  - Reset asserted mid-cycle overrides a pending write.
- Unknown inputs: not required to be handled. Address fields are fully decoded, so every 5-bit address is valid.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When WriteEnable=1, rd!=0, rst=1 and rs1==rd, data1=data combinationally, before the edge. The same applies to rs2/data2.
  - rd=0 is never forwarded.
  - Reset still forces reads to 0.
- Undefined: reads return stored contents only; the write becomes visible after the clock edge.

Test Plan:
- Hold rst=0 for one cycle with random addresses -> data1=data2=0. Release rst; read all 32 addresses -> 0.
- rst=1, WriteEnable=1, rd=2, data=0x00000001, rs1=3, rs2=2; one rising edge -> data2=0x00000001, data1=0x00000000.
- WriteEnable=1, rd=0, data=0xFFFFFFFF; edge; rs1=0, rs2=2 -> data1=0x00000000, data2=0x00000001 (x0 unwritable, x2 retained).
- WriteEnable=0, rd=1, data=0xFFFFFFFF; edge; rs1=1 -> data1=0x00000000. Then WriteEnable=1; edge -> data1=0xFFFFFFFF.
- Write x5=0xA5A5A5A5 and x31=0x5A5A5A5A; rs1=rs2=5 -> both 0xA5A5A5A5. rs2=31 -> 0x5A5A5A5A. Assert rst=0 mid-cycle -> both outputs 0 without waiting for an edge.
- Same-cycle read of rd=7 while writing 0x12345678:
  - default build: data1 shows the old value until the edge.
  - with REGFILE_BYPASS_EN: data1=0x12345678 before the edge.
  - rd=0 with rs1=0 -> 0 in both builds.
